// File: rtl/div_pkg.sv
// Shared types and constants for the DIV/DIVU sequencing controller.
// The DIV_ZERO_BYPASS_EN option itself lives in div_ctrl.sv.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } div_state_e;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 64;

    // Divider result layout: {remainder, quotient}
    localparam int unsigned REM_MSB = 63;
    localparam int unsigned REM_LSB = 32;
    localparam int unsigned QUO_MSB = 31;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/div_if.sv
// Controller-to-divider bus: the controller is the master, the iterative divider the slave.
interface div_if;
    import div_pkg::*;

    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] div_a;
    logic [DATA_W-1:0] div_b;
    logic              div_enable;
    logic              div_annul;
    logic              div_ready;
    logic [RES_W-1:0]  div_result;

    modport master (
        output div_start, div_signed, div_a, div_b, div_enable, div_annul,
        input  div_ready, div_result
    );

    modport slave (
        input  div_start, div_signed, div_a, div_b, div_enable, div_annul,
        output div_ready, div_result
    );

endinterface

// File: rtl/div_ctrl.sv
// EX-stage sequencer for DIV/DIVU: drives an external divider and writes HI/LO.
// Optional DIV_ZERO_BYPASS_EN: zero divisor skips the divider (LO = all ones, HI = dividend).
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_div_valid,
    input  logic              ex_signed,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic              flush,
    input  logic              stall_in,
    div_if.master             dv,
    output logic              div_stall,
    output logic              hi_we,
    output logic              lo_we,
    output logic [DATA_W-1:0] hi_wdata,
    output logic [DATA_W-1:0] lo_wdata,
    output logic              div_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    div_state_e        state;
    logic [CW-1:0]     wait_cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_signed;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic              wr_pend;
    logic              annul_q;
    logic              timeout_q;
    logic              accept;

    assign accept = ex_div_valid & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            res_hi    <= '0;
            res_lo    <= '0;
            wr_pend   <= 1'b0;
            annul_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wr_pend   <= 1'b0;
            annul_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a      <= ex_a;
                        op_b      <= ex_b;
                        op_signed <= ex_signed;
                        wait_cnt  <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                        if (ex_b == '0) begin
                            res_hi  <= ex_a;
                            res_lo  <= '1;
                            wr_pend <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= LOAD;
                        end
`else
                        state <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    if (flush) begin
                        annul_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // flush outranks a same-cycle div_ready
                    if (flush) begin
                        annul_q <= 1'b1;
                        state   <= IDLE;
                    end else if (dv.div_ready) begin
                        res_hi  <= dv.div_result[REM_MSB:REM_LSB];
                        res_lo  <= dv.div_result[QUO_MSB:0];
                        wr_pend <= 1'b1;
                        state   <= DONE;
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        annul_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (flush || !stall_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dv.div_start  = (state == LOAD) || (state == WAIT);
    assign dv.div_signed = op_signed;
    assign dv.div_a      = op_a;
    assign dv.div_b      = op_b;
    assign dv.div_enable = ~stall_in;
    assign dv.div_annul  = annul_q;

    // Acceptance stall is combinational so the hazard unit holds EX in the capture cycle
    assign div_stall   = dv.div_start | (rst & (state == IDLE) & accept);
    assign hi_we       = wr_pend & ~flush;
    assign lo_we       = wr_pend & ~flush;
    assign hi_wdata    = res_hi;
    assign lo_wdata    = res_lo;
    assign div_timeout = timeout_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider and a HI/LO write scoreboard.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid;
    logic        ex_signed;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        flush;
    logic        stall_in;
    logic        div_stall;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        div_timeout;

    div_if dv ();

    div_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_valid (ex_div_valid),
        .ex_signed    (ex_signed),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .flush        (flush),
        .stall_in     (stall_in),
        .dv           (dv),
        .div_stall    (div_stall),
        .hi_we        (hi_we),
        .lo_we        (lo_we),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata),
        .div_timeout  (div_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int writes   = 0;

    // behavioural divider state
    int          dcnt      = 0;
    int          dlat      = 8;
    bit          dbusy     = 1'b0;
    bit          dready_en = 1'b1;
    logic [31:0] da = '0;
    logic [31:0] db = '0;
    logic        ds = 1'b0;

    logic s_start, s_annul, s_stall, s_we, s_timeout, s_ready;

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit ZERO_NORMAL = 1'b0;
    localparam int ZERO_LAT    = 1;
`else
    localparam bit ZERO_NORMAL = 1'b1;
    localparam int ZERO_LAT    = 10;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // One clock cycle: drive divider response, sample, score writes, advance.
    task automatic step();
        exp_t e;
        if (dbusy) dcnt++;
        dv.div_ready  = dready_en && dbusy && (dcnt == dlat);
        dv.div_result = model_div(da, db, ds);
        #1;
        s_start   = dv.div_start;
        s_annul   = dv.div_annul;
        s_stall   = div_stall;
        s_we      = hi_we;
        s_timeout = div_timeout;
        s_ready   = dv.div_ready;
        chk("enable", dv.div_enable, !stall_in);
        chk("we_pair", lo_we, hi_we);
        if (hi_we) begin
            writes++;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hi_wdata", hi_wdata, e.hi);
                chk("lo_wdata", lo_wdata, e.lo);
                if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
            end
        end
        if (!dv.div_start) begin
            dbusy = 1'b0;
        end else if (!dbusy) begin
            dbusy = 1'b1;
            dcnt  = 0;
            da    = dv.div_a;
            db    = dv.div_b;
            ds    = dv.div_signed;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                         input int lat);
        ex_div_valid = 1'b1;
        ex_a         = a;
        ex_b         = b;
        ex_signed    = s;
        if (push) sb.push_back('{hi: ehi, lo: elo, lat: lat});
        acc_cyc = cyc;
        step();
        chk("accept_stall", s_stall, 1);
        ex_div_valid = 1'b0;
    endtask

    task automatic run_to_write(input bit normal);
        int w0;
        bit got;
        w0  = writes;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (!normal) chk("bypass_start", s_start, 0);
            if (writes != w0) begin
                got = 1'b1;
                chk("done_stall", s_stall, 0);
            end else begin
                chk("busy_stall", s_stall, 1);
                if (normal) chk("busy_start", s_start, 1);
            end
        end
        chk("write_seen", writes - w0, 1);
    endtask

    initial begin
        int          w0;
        int          tcyc;
        int          tcount;
        logic [31:0] ra, rb;
        logic [63:0] m;

        rst           = 1'b0;
        ex_div_valid  = 1'b1;
        ex_signed     = 1'b0;
        ex_a          = 32'h1234;
        ex_b          = 32'h5;
        flush         = 1'b0;
        stall_in      = 1'b1;
        dv.div_ready  = 1'b0;
        dv.div_result = '0;

        // reset: everything quiet even with a request present
        step();
        chk("rst_start", s_start, 0);
        chk("rst_stall", s_stall, 0);
        chk("rst_we", s_we, 0);
        chk("rst_annul", s_annul, 0);
        chk("rst_timeout", s_timeout, 0);
        chk("rst_hi", hi_wdata, 0);
        chk("rst_lo", lo_wdata, 0);
        chk("rst_div_a", dv.div_a, 0);
        stall_in     = 1'b0;
        ex_div_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        // DIVU 100/7
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'h2, 32'hE, 10);
        run_to_write(1'b1);
        step();
        chk("no_repeat", s_we, 0);

        // DIV -7/2
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_to_write(1'b1);
        step();

        // flush on the third WAIT cycle
        w0 = writes;
        issue(32'd500, 32'd3, 1'b0, 1'b0, '0, '0, -1);
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("flush_annul", s_annul, 1);
        chk("flush_start", s_start, 0);
        chk("flush_stall", s_stall, 0);
        step();
        chk("annul_one_cycle", s_annul, 0);
        for (int i = 0; i < 10; i++) step();
        chk("flush_nowrite", writes - w0, 0);

        // flush coincides with div_ready
        dlat = 3;
        w0   = writes;
        issue(32'd900, 32'd4, 1'b0, 1'b0, '0, '0, -1);
        step();
        step();
        step();
        flush = 1'b1;
        step();
        chk("ready_at_flush", s_ready, 1);
        flush = 1'b0;
        step();
        chk("flush_ready_annul", s_annul, 1);
        for (int i = 0; i < 6; i++) step();
        chk("flush_ready_nowrite", writes - w0, 0);
        dlat = 8;

        // stall_in held three cycles in DONE
        stall_in = 1'b1;
        issue(32'd1000, 32'd10, 1'b0, 1'b1, 32'd0, 32'd100, 10);
        run_to_write(1'b1);
        step();
        chk("stall_hold_we2", s_we, 0);
        step();
        chk("stall_hold_we3", s_we, 0);
        stall_in = 1'b0;
        step();
        chk("stall_release_we", s_we, 0);
        m = model_div(32'h1234_5678, 32'hFFFF_FF00, 1'b1);
        issue(32'h1234_5678, 32'hFFFF_FF00, 1'b1, 1'b1, m[63:32], m[31:0], 10);
        run_to_write(1'b1);
        step();

        // flush during the first DONE cycle
        w0 = writes;
        issue(32'd77, 32'd5, 1'b0, 1'b0, '0, '0, -1);
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        step();
        chk("done_flush_we", s_we, 0);
        flush = 1'b0;
        step();
        chk("done_flush_after", s_we, 0);
        chk("done_flush_nowrite", writes - w0, 0);

        // flush in IDLE
        ex_div_valid = 1'b1;
        ex_a         = 32'd9;
        ex_b         = 32'd3;
        flush        = 1'b1;
        step();
        chk("idle_flush_stall", s_stall, 0);
        ex_div_valid = 1'b0;
        flush        = 1'b0;
        step();
        chk("idle_flush_start", s_start, 0);

        // a few ordinary operations
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 1000);
            m  = model_div(ra, rb, k[0]);
            issue(ra, rb, k[0], 1'b1, m[63:32], m[31:0], 10);
            run_to_write(1'b1);
            step();
        end

        // timeout with no div_ready
        dready_en = 1'b0;
        w0        = writes;
        tcyc      = -1;
        tcount    = 0;
        issue(32'd64, 32'd8, 1'b0, 1'b0, '0, '0, -1);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (s_timeout) begin
                tcount++;
                if (tcyc < 0) tcyc = i;
                chk("timeout_annul", s_annul, 1);
            end
        end
        chk("timeout_count", tcount, 1);
        chk("timeout_cycle", tcyc, 18);
        chk("timeout_nowrite", writes - w0, 0);
        dready_en = 1'b1;

        // reset mid-operation, then a zero divisor
        w0 = writes;
        issue(32'd100, 32'd3, 1'b0, 1'b0, '0, '0, -1);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b0;
        step();
        chk("midrst_start", s_start, 0);
        chk("midrst_stall", s_stall, 0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("midrst_nowrite", writes - w0, 0);
        issue(32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 32'hFFFF_FFFF, ZERO_LAT);
        run_to_write(ZERO_NORMAL);
        step();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
